rw_mlp_feature_sequencer: RTL and testbench
===========================================

Name: rw_mlp_feature_sequencer

Overview:
Upstream framing stage for the red-wine MLP regressor top. Accepts one 4-bit feature per valid/ready beat and assembles NUM_A features into the flat `inp` vector that drives the combinational classifier. It holds that vector stable for a fixed settle window, then captures the classifier's OUTWIDTH-bit result. The result is presented on a valid/ready output channel. This replaces file-driven stimulus with a clocked streaming interface for silicon use.

Parameters:
WIDTH_A, 4, bits per feature
NUM_A, 11, features per frame
OUTWIDTH, 20, classifier result width
SETTLE_CYC, 4, cycles the assembled vector is held before result capture; must be >=1
CNT_W, 16, width of the completed-frame counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
feat_valid  in  1  feature beat valid
feat_ready  out  1  sequencer can accept a feature
feat_data  in  WIDTH_A  feature value
feat_last  in  1  marks final feature of a frame
inp  out  NUM_A*WIDTH_A  assembled vector to classifier; slot i at bits [(i+1)*WIDTH_A-1 : i*WIDTH_A]
out_cls  in  OUTWIDTH  classifier result (combinational from inp)
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  OUTWIDTH  captured result
frame_err  out  1  one-cycle pulse on framing error
frame_cnt  out  CNT_W  completed results, wraps modulo 2^CNT_W
busy  out  1  high in SETTLE or HOLD

Behaviour:
- Reset, sampled at a clock edge:
  - state=LOAD, idx=0, settle counter=0.
  - inp=0, res_data=0, res_valid=0, frame_err=0, frame_cnt=0.
  - Reset mid-frame or mid-result discards everything. No handshake completes on a reset edge.
- FSM states: LOAD, SETTLE, HOLD.
- LOAD:
  - feat_ready=1, busy=0.
  - Beat = feat_valid & feat_ready at an edge. On a beat, feat_data is written into slot idx. Other slots keep their prior values; there is no clear between frames.
  - Beat with idx<NUM_A-1 and feat_last=0: idx++.
  - Beat with idx<NUM_A-1 and feat_last=1 (early last): the slot is still written, frame_err pulses next cycle, idx←0, and the state stays LOAD. The partial frame is dropped.
  - Beat with idx==NUM_A-1: slot written, idx←0, settle counter←0, state←SETTLE.
    - If feat_last=0 on this beat, frame_err pulses but the frame is still processed.
    - The frame always ends on the NUM_A-th beat.
- SETTLE:
  - feat_ready=0, busy=1, inp held stable.
  - Each edge: if counter==SETTLE_CYC-1, then res_data←out_cls, res_valid←1, state←HOLD. Otherwise counter++.
  - Result: res_valid is first high exactly SETTLE_CYC cycles after the edge that accepted the final feature.
- HOLD:
  - feat_ready=0, busy=1; inp and res_data held stable.
  - On an edge with res_ready=1: res_valid←0, frame_cnt++ (wrapping), state←LOAD.
  - The next frame's first beat can be accepted on the cycle after the result handshake. There is no overlap.
  - res_ready while res_valid=0 has no effect.
- frame_err:
  - Registered, high for exactly one cycle per offending beat; otherwise 0.
  - Back-to-back early-last beats give consecutive pulses.
- feat_valid during SETTLE/HOLD is ignored. The upstream must hold feat_data until ready.
- frame_cnt at 2^CNT_W-1 plus one handshake reads 0.
- All outputs are registered except feat_ready and busy, which decode directly from state.

Test Plan:
1. Reset, then stream features 1..11 (feat_last on the 11th beat), bench model drives out_cls=20'h0ABCD, res_ready=1 → inp=44'hBA987654321; res_valid rises 4 cycles after the 11th accept edge; res_data=20'h0ABCD; frame_cnt=1; no frame_err.
2. Hold res_ready=0 for 10 cycles after res_valid, toggle feat_valid meanwhile → res_valid stays 1, feat_ready stays 0, inp unchanged, frame_cnt stays 0 until res_ready=1, then 1 the next cycle.
3. Send 5 beats with feat_last on the 5th, then a full valid frame of all 4'hF → one frame_err pulse after beat 5; idx restarts at 0; the second frame gives inp=44'hFFFFFFFFFFF and frame_cnt=1.
4. Full 11-beat frame with feat_last never asserted → frame_err pulses once after beat 11; the result is still produced and frame_cnt increments.
5. Assert rst during SETTLE (2 cycles after last accept) → next cycle res_valid=0, inp=0, state LOAD, feat_ready=1; the stale result is never presented.
6. SETTLE_CYC=1 build with CNT_W=2, run 5 back-to-back frames with res_ready=1 → res_valid rises 1 cycle after each last accept; frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/rw_mlp_feature_sequencer.sv
// Streams 4-bit features into the classifier input vector, holds it for a settle
// window, then captures the classifier result onto a valid/ready output channel.
module rw_mlp_feature_sequencer #(
    parameter int WIDTH_A    = 4,
    parameter int NUM_A      = 11,
    parameter int OUTWIDTH   = 20,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    output logic                       feat_ready,
    input  logic [WIDTH_A-1:0]         feat_data,
    input  logic                       feat_last,
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    input  logic [OUTWIDTH-1:0]        out_cls,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUTWIDTH-1:0]        res_data,
    output logic                       frame_err,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic                       busy
);

    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_A - 1);
    localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [SET_W-1:0]           settle_q, settle_d;
    logic [NUM_A*WIDTH_A-1:0]   inp_q, inp_d;
    logic [OUTWIDTH-1:0]        res_data_q, res_data_d;
    logic                       res_valid_q, res_valid_d;
    logic                       frame_err_q, frame_err_d;
    logic [CNT_W-1:0]           frame_cnt_q, frame_cnt_d;
    logic                       beat;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds its payload stable until that edge.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        inp_d       = inp_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        feat_ready  = (state_q == S_LOAD);
        busy        = (state_q == S_SETTLE) || (state_q == S_HOLD);
        beat        = feat_valid && feat_ready;

        case (state_q)
            S_LOAD: begin
                if (beat) begin
                    for (int i = 0; i < NUM_A; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            inp_d[i*WIDTH_A +: WIDTH_A] = feat_data;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        // A frame always closes on its last slot; a missing last flag is
                        // flagged but the frame still goes through.
                        idx_d       = '0;
                        settle_d    = '0;
                        state_d     = S_SETTLE;
                        frame_err_d = !feat_last;
                    end else if (feat_last) begin
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == LAST_SETTLE) begin
                    res_data_d  = out_cls;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            settle_q    <= '0;
            inp_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            inp_q       <= inp_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign inp       = inp_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rw_mlp_feature_sequencer.sv
// Directed bench for rw_mlp_feature_sequencer: default build plus a
// SETTLE_CYC=1 / CNT_W=2 build sharing the feature and result inputs.
module tb_rw_mlp_feature_sequencer;

    logic        clk;
    logic        rst;
    logic        rst6;
    logic        feat_valid;
    logic [3:0]  feat_data;
    logic        feat_last;
    logic [19:0] out_cls;
    logic        res_ready;

    logic        feat_ready, res_valid, frame_err, busy;
    logic [43:0] inp;
    logic [19:0] res_data;
    logic [15:0] frame_cnt;

    logic        feat_ready6, res_valid6, frame_err6, busy6;
    logic [43:0] inp6;
    logic [19:0] res_data6;
    logic [1:0]  frame_cnt6;

    int checks;
    int failures;

    rw_mlp_feature_sequencer u_dut (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_data(feat_data), .feat_last(feat_last),
        .inp(inp), .out_cls(out_cls),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .busy(busy)
    );

    rw_mlp_feature_sequencer #(.SETTLE_CYC(1), .CNT_W(2)) u_dut6 (
        .clk(clk), .rst(rst6),
        .feat_valid(feat_valid), .feat_ready(feat_ready6),
        .feat_data(feat_data), .feat_last(feat_last),
        .inp(inp6), .out_cls(out_cls),
        .res_valid(res_valid6), .res_ready(res_ready), .res_data(res_data6),
        .frame_err(frame_err6), .frame_cnt(frame_cnt6), .busy(busy6)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 ns after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] d, input logic last);
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = last;
        step();
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        rst6       = 1'b1;
        feat_valid = 1'b0;
        feat_data  = '0;
        feat_last  = 1'b0;
        out_cls    = 20'h0ABCD;
        res_ready  = 1'b1;
        step();
        step();

        // Reset state
        check("rst_res_valid", res_valid, 0);
        check("rst_inp", inp, 0);
        check("rst_res_data", res_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_feat_ready", feat_ready, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // 1: basic frame 1..11, settle latency of 4
        for (int i = 1; i <= 11; i++) send_beat(4'(i), i == 11);
        check("t1_inp", inp, 44'hBA987654321);
        check("t1_busy", busy, 1);
        check("t1_feat_ready", feat_ready, 0);
        check("t1_frame_err", frame_err, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t1_res_valid_early", res_valid, 0);
        end
        step();
        check("t1_res_valid", res_valid, 1);
        check("t1_res_data", res_data, 20'h0ABCD);
        check("t1_cnt_before", frame_cnt, 0);
        step();
        check("t1_res_valid_drop", res_valid, 0);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_feat_ready_back", feat_ready, 1);

        // 2: backpressure on the result channel
        do_reset();
        res_ready = 1'b0;
        out_cls   = 20'h55AA5;
        for (int i = 0; i < 11; i++) send_beat(4'(i + 5), i == 10);
        for (int i = 0; i < 4; i++) step();
        check("t2_res_valid", res_valid, 1);
        for (int i = 0; i < 10; i++) begin
            feat_valid = ~feat_valid;
            feat_data  = 4'h0;
            step();
            check("t2_hold_valid", res_valid, 1);
            check("t2_hold_ready", feat_ready, 0);
            check("t2_hold_inp", inp, 44'hFEDCBA98765);
            check("t2_hold_cnt", frame_cnt, 0);
        end
        feat_valid = 1'b0;
        check("t2_res_data", res_data, 20'h55AA5);
        res_ready = 1'b1;
        step();
        check("t2_frame_cnt", frame_cnt, 1);
        check("t2_res_valid_drop", res_valid, 0);
        check("t2_feat_ready", feat_ready, 1);
        check("t2_inp_kept", inp, 44'hFEDCBA98765);

        // 3: early last drops the partial frame, next frame is clean
        do_reset();
        out_cls = 20'h12345;
        for (int i = 1; i <= 5; i++) send_beat(4'(i), i == 5);
        check("t3_err_pulse", frame_err, 1);
        check("t3_still_load", feat_ready, 1);
        check("t3_partial_inp", inp, 44'h00000054321);
        step();
        check("t3_err_cleared", frame_err, 0);
        for (int i = 0; i < 11; i++) send_beat(4'hF, i == 10);
        check("t3_no_err", frame_err, 0);
        check("t3_inp", inp, 44'hFFFFFFFFFFF);
        check("t3_busy", busy, 1);
        for (int i = 0; i < 4; i++) step();
        check("t3_res_valid", res_valid, 1);
        check("t3_res_data", res_data, 20'h12345);
        step();
        check("t3_frame_cnt", frame_cnt, 1);

        // 4: full frame without feat_last still processed, one error pulse
        do_reset();
        out_cls = 20'hFEDCB;
        for (int i = 0; i < 11; i++) send_beat(4'(i), 1'b0);
        check("t4_err_pulse", frame_err, 1);
        check("t4_busy", busy, 1);
        check("t4_inp", inp, 44'hA9876543210);
        step();
        check("t4_err_once", frame_err, 0);
        for (int i = 0; i < 3; i++) step();
        check("t4_res_valid", res_valid, 1);
        check("t4_res_data", res_data, 20'hFEDCB);
        step();
        check("t4_frame_cnt", frame_cnt, 1);

        // 5: reset during settle discards the frame
        do_reset();
        for (int i = 1; i <= 11; i++) send_beat(4'(i), i == 11);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_res_valid", res_valid, 0);
        check("t5_inp", inp, 0);
        check("t5_feat_ready", feat_ready, 1);
        check("t5_busy", busy, 0);
        check("t5_frame_cnt", frame_cnt, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t5_no_stale", res_valid, 0);
        end

        // 6: SETTLE_CYC=1, CNT_W=2 build, back-to-back frames, counter wraps
        rst  = 1'b1;
        rst6 = 1'b1;
        step();
        rst6      = 1'b0;
        res_ready = 1'b1;
        check("t6_rst_cnt", frame_cnt6, 0);
        for (int f = 0; f < 5; f++) begin
            logic [1:0] exp_cnt[5];
            exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            out_cls = 20'h10000 + 20'(f);
            for (int i = 0; i < 11; i++) send_beat(4'(f + 1), i == 10);
            check("t6_res_valid_early", res_valid6, 0);
            check("t6_busy", busy6, 1);
            step();
            check("t6_res_valid", res_valid6, 1);
            check("t6_res_data", res_data6, 20'h10000 + 20'(f));
            step();
            check("t6_frame_cnt", frame_cnt6, exp_cnt[f]);
            check("t6_res_valid_drop", res_valid6, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
